// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants and state encoding for the UART framebuffer command decoder.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA,
    ST_EXEC_WR,
    ST_EXEC_RD,
    ST_RD_WAIT,
    ST_RESP
  } state_t;

  // True in the states where the next frame byte is being awaited.
  function automatic logic awaits_byte(state_t s);
    return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Bundles the UART rx/tx handshakes and the framebuffer access bus of the decoder.
interface uart_cmd_decoder_if #(
  parameter int ADDR_W = 16
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // Host side: UART receiver, UART transmitter and framebuffer together.
  modport master (
    output rx_valid, rx_data, tx_ready, mem_rdata,
    input  tx_valid, tx_data, mem_we, mem_re, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready, mem_rdata,
    output tx_valid, tx_data, mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: saturating, expires after TIMEOUT enabled cycles without a clear.
module uart_cmd_timer #(
  parameter int TIMEOUT = 434000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Assembles UART bytes into framebuffer read/write commands and returns one response byte each.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 434000
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_cmd_decoder_if.slave   bus
);

  state_t            state_q, state_d;
  logic              is_write_q, is_write_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              mem_we, mem_re;

  logic timer_en, timer_clear, timer_expired;

  assign timer_en    = awaits_byte(state_q);
  // Clearing outside the waiting states guarantees a fresh count on entering ADDR_HI.
  assign timer_clear = bus.rx_valid || !timer_en;

  uart_cmd_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_hi_d  = addr_hi_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    tx_data_d  = tx_data_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          if ((bus.rx_data == OP_WRITE) || (bus.rx_data == OP_READ)) begin
            is_write_d = (bus.rx_data == OP_WRITE);
            state_d    = ST_ADDR_HI;
          end else begin
            tx_data_d = RSP_NAK;
            state_d   = ST_RESP;
          end
        end
      end
      // A byte arriving in the expiry cycle takes priority over the timeout.
      ST_ADDR_HI: begin
        if (bus.rx_valid) begin
          addr_hi_d = bus.rx_data;
          state_d   = ST_ADDR_LO;
        end else if (timer_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR_LO: begin
        if (bus.rx_valid) begin
          mem_addr_d = ADDR_W'({addr_hi_q, bus.rx_data});
          state_d    = is_write_q ? ST_DATA : ST_EXEC_RD;
        end else if (timer_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bus.rx_valid) begin
          wdata_d = bus.rx_data;
          state_d = ST_EXEC_WR;
        end else if (timer_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC_WR: begin
        mem_we    = 1'b1;
        tx_data_d = RSP_ACK;
        state_d   = ST_RESP;
      end
      ST_EXEC_RD: begin
        mem_re  = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        tx_data_d = bus.mem_rdata;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (bus.tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      is_write_q <= 1'b0;
      addr_hi_q  <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_hi_q  <= addr_hi_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.tx_valid  = (state_q == ST_RESP);
  assign bus.tx_data   = tx_data_q;
  assign bus.mem_we    = mem_we;
  assign bus.mem_re    = mem_re;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench: stimulus pushes expected strobes/responses, a negedge monitor pops and compares.
module tb_uart_cmd_decoder;
  import uart_cmd_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 40;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_cmd_decoder_if #(.ADDR_W(ADDR_W)) bus ();

  uart_cmd_decoder #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic [15:0] written[$];
  int          tx_done    = 0;
  int          resp_total = 0;
  bit          hold_low   = 1'b0;

  logic [7:0] fb [0:65535];
  logic [7:0] ref_mem [int];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_read(logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_byte(int'(a));
  endfunction

  // Framebuffer responder: read data is valid only in the cycle after mem_re, noise otherwise.
  initial begin
    bit          pend;
    logic [15:0] pa;
    for (int i = 0; i < 65536; i++) fb[i] = init_byte(i);
    fb[16'h0010]  = 8'h5C;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      pend = bus.mem_re;
      pa   = bus.mem_addr;
      if (bus.mem_we) fb[bus.mem_addr] = bus.mem_wdata;
      @(posedge clk);
      #1;
      bus.mem_rdata = pend ? fb[pa] : 8'($urandom);
    end
  end

  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  initial begin
    wr_t         w;
    logic [15:0] ra;
    bit          prev_valid;
    bit          prev_hs;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        continue;
      end
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) check("unexpected_mem_we", 32'd1, 32'd0);
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
          check("wr_data", 32'(bus.mem_wdata), 32'(w.data));
        end
      end
      if (bus.mem_re) begin
        if (exp_rd.size() == 0) check("unexpected_mem_re", 32'd1, 32'd0);
        else begin
          ra = exp_rd.pop_front();
          check("rd_addr", 32'(bus.mem_addr), 32'(ra));
        end
      end
      if (prev_valid && !prev_hs) check("tx_valid_held", 32'(bus.tx_valid), 32'd1);
      if (bus.tx_valid) begin
        if (exp_tx.size() == 0) check("unexpected_tx_valid", 32'd1, 32'd0);
        else begin
          check("tx_data", 32'(bus.tx_data), 32'(exp_tx[0]));
          if (bus.tx_ready) begin
            void'(exp_tx.pop_front());
            tx_done++;
          end
        end
      end
      prev_valid = bus.tx_valid;
      prev_hs    = bus.tx_valid && bus.tx_ready;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic wait_resp();
    resp_total++;
    for (int i = 0; i < 500 && tx_done < resp_total; i++) idle(1);
    if (tx_done < resp_total) begin
      check("resp_wait_bound", 32'(tx_done), 32'(resp_total));
      tx_done = resp_total;
    end
  endtask

  // With hold > 0, the response is back-pressured for that many cycles before release.
  task automatic finish_resp(int hold);
    if (hold > 0) begin
      idle(hold);
      check("resp_pending_under_hold", 32'(bus.tx_valid), 32'd1);
      hold_low = 1'b0;
    end
    wait_resp();
  endtask

  task automatic do_write(logic [15:0] a, logic [7:0] d, int gap, int hold);
    hold_low = (hold > 0);
    exp_wr.push_back('{addr: a, data: d});
    exp_tx.push_back(RSP_ACK);
    ref_mem[int'(a)] = d;
    written.push_back(a);
    send_byte(OP_WRITE); idle(gap);
    send_byte(a[15:8]);  idle(gap);
    send_byte(a[7:0]);   idle(gap);
    send_byte(d);
    finish_resp(hold);
  endtask

  task automatic do_read(logic [15:0] a, int gap, int hold);
    hold_low = (hold > 0);
    exp_rd.push_back(a);
    exp_tx.push_back(ref_read(a));
    send_byte(OP_READ); idle(gap);
    send_byte(a[15:8]); idle(gap);
    send_byte(a[7:0]);
    finish_resp(hold);
  endtask

  task automatic do_bad(logic [7:0] b, int hold);
    hold_low = (hold > 0);
    exp_tx.push_back(RSP_NAK);
    send_byte(b);
    finish_resp(hold);
  endtask

  task automatic do_abandon(logic [15:0] a);
    bit w;
    int n;
    w = 1'($urandom_range(0, 1));
    n = w ? $urandom_range(1, 3) : $urandom_range(1, 2);
    send_byte(w ? OP_WRITE : OP_READ);
    if (n >= 2) send_byte(a[15:8]);
    if (n >= 3) send_byte(a[7:0]);
    idle(TIMEOUT + $urandom_range(0, 3));
    check("abandon_no_tx", 32'(bus.tx_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
    check({tag, "_tx_data"},   32'(bus.tx_data),   32'd0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_mem_re"},    32'(bus.mem_re),    32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  b;
    int          kind;
    int          gap;
    int          hold;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n        = 1'b0;
    ref_mem[16'h0010] = 8'h5C;
    #12;
    check_reset_outputs("por");
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Directed frames from the test plan
    do_write(16'h1234, 8'hAB, 0, 10);
    do_read(16'h0010, 0, 0);
    do_bad(8'h00, 0);
    do_write(16'h00FE, 8'h3C, 0, 0);

    send_byte(OP_WRITE);
    send_byte(8'h12);
    idle(TIMEOUT);
    check("timeout_no_tx", 32'(bus.tx_valid), 32'd0);
    do_read(16'h0001, 0, 0);

    // Largest inter-byte gap that still completes a frame
    do_write(16'hBEEF, 8'h77, TIMEOUT - 1, 0);
    do_read(16'hBEEF, TIMEOUT - 1, 0);

    // Back-pressure with stray bytes arriving during RESP
    hold_low = 1'b1;
    exp_wr.push_back('{addr: 16'h4000, data: 8'h99});
    exp_tx.push_back(RSP_ACK);
    ref_mem[int'(16'h4000)] = 8'h99;
    send_byte(OP_WRITE); send_byte(8'h40); send_byte(8'h00); send_byte(8'h99);
    idle(3);
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 2);
      send_byte(kind == 0 ? OP_WRITE : (kind == 1 ? OP_READ : 8'h00));
      idle(4);
    end
    check("bp_tx_valid_after_50", 32'(bus.tx_valid), 32'd1);
    hold_low = 1'b0;
    wait_resp();
    do_read(16'h4000, 0, 0);

    // Reset in the middle of a frame
    send_byte(OP_WRITE);
    send_byte(8'hFF);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midcmd");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    do_read(16'h1234, 0, 0);

    // Reset while a response is pending discards it
    hold_low = 1'b1;
    exp_tx.push_back(RSP_NAK);
    send_byte(8'hA5);
    idle(3);
    check("pending_before_reset", 32'(bus.tx_valid), 32'd1);
    rst_n = 1'b0;
    exp_tx.delete();
    #1;
    check("pending_dropped_by_reset", 32'(bus.tx_valid), 32'd0);
    hold_low = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    check("no_resp_after_reset", 32'(bus.tx_valid), 32'd0);

    // Randomized frames
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      gap  = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 2);
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(5, 15) : 0;
      if (written.size() > 0 && $urandom_range(0, 1) == 1)
        a = written[$urandom_range(0, written.size() - 1)];
      else
        a = 16'($urandom);
      if (kind < 4) begin
        do_write(a, 8'($urandom), gap, hold);
      end else if (kind < 7) begin
        do_read(a, gap, hold);
      end else if (kind == 7) begin
        do b = 8'($urandom); while (b == OP_WRITE || b == OP_READ);
        do_bad(b, hold);
      end else begin
        do_abandon(a);
      end
    end

    idle(10);
    check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    check("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
    check("final_idle_tx", 32'(bus.tx_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
